// File: rtl/instruction_pkg.sv
// Shared divide-unit types: FSM state encoding, funct3 operation codes and op decode helpers.
package instruction_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  localparam logic [1:0] FUNCT3_DIV  = 2'b00;
  localparam logic [1:0] FUNCT3_DIVU = 2'b01;
  localparam logic [1:0] FUNCT3_REM  = 2'b10;
  localparam logic [1:0] FUNCT3_REMU = 2'b11;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == FUNCT3_DIV) || (op == FUNCT3_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == FUNCT3_REM) || (op == FUNCT3_REMU);
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between the execution stage (master) and the divider (slave).
interface div_sequencer_if;
  logic        start;
  logic        kill;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        div_last;
  logic [31:0] result;
  logic [31:0] Qo;

  modport master (
    output start, kill, op, dividend, divisor,
    input  busy, div_last, result, Qo
  );

  modport slave (
    input  start, kill, op, dividend, divisor,
    output busy, div_last, result, Qo
  );
endinterface

// File: rtl/div_step.sv
// One restoring radix-2 step: shift in a dividend bit, subtract the divisor if it fits.
module div_step (
  input  logic [32:0] rem_in,
  input  logic        dvd_bit,
  input  logic [31:0] divisor,
  output logic [32:0] rem_out,
  output logic        q_bit
);
  logic [33:0] shifted;
  logic [32:0] diff;

  assign shifted = {rem_in, dvd_bit};
  // The difference is only kept when it fits, so 33 bits of it are enough.
  assign diff    = shifted[32:0] - {1'b0, divisor};
  assign q_bit   = (shifted >= {2'b00, divisor});
  assign rem_out = q_bit ? diff : shifted[32:0];
endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): PREP, 32 restoring steps, sign FIX, DONE.
// Define DIV_FASTPATH_EN to resolve divide-by-zero and signed overflow directly to DONE.
module div_sequencer
  import instruction_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  div_sequencer_if.slave bus
);
  div_state_e  state_reg, state_next;
  logic [4:0]  count_reg;
  logic [1:0]  op_reg;
  logic [31:0] a_reg, b_reg;
  logic [31:0] dvd_reg, dvs_reg, quo_reg;
  logic [32:0] rem_reg;
  logic [31:0] result_reg, qo_reg;
  logic        neg_q_reg, neg_r_reg, div0_reg, ovf_reg;

  logic        accept, sgn;
  logic [32:0] rem_step;
  logic        q_step;
  logic [31:0] q_fix, r_fix;

  assign accept = ((state_reg == IDLE) || (state_reg == DONE)) && bus.start && !bus.kill;
  assign sgn    = op_is_signed(op_reg);

`ifdef DIV_FASTPATH_EN
  logic        fast_div0, fast_ovf, fast_hit;
  logic [31:0] fast_q, fast_r;

  assign fast_div0 = (bus.divisor == 32'h0000_0000);
  assign fast_ovf  = op_is_signed(bus.op) && (bus.dividend == 32'h8000_0000)
                     && (bus.divisor == 32'hFFFF_FFFF);
  assign fast_hit  = fast_div0 || fast_ovf;
  assign fast_q    = fast_div0 ? 32'hFFFF_FFFF : 32'h8000_0000;
  assign fast_r    = fast_div0 ? bus.dividend : 32'h0000_0000;
`endif

  div_step u_step (
    .rem_in  (rem_reg),
    .dvd_bit (dvd_reg[31]),
    .divisor (dvs_reg),
    .rem_out (rem_step),
    .q_bit   (q_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (bus.kill) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
`ifdef DIV_FASTPATH_EN
            state_next = fast_hit ? DONE : PREP;
`else
            state_next = PREP;
`endif
          end else begin
            state_next = IDLE;
          end
        end
        PREP:    state_next = ITER;
        ITER:    if (count_reg == 5'd0) state_next = FIX;
        FIX:     state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Sign correction, then the architectural override values for the two corner cases.
  always_comb begin
    q_fix = neg_q_reg ? -quo_reg : quo_reg;
    r_fix = neg_r_reg ? -rem_reg[31:0] : rem_reg[31:0];
    if (div0_reg) begin
      q_fix = 32'hFFFF_FFFF;
      r_fix = a_reg;
    end else if (ovf_reg) begin
      q_fix = 32'h8000_0000;
      r_fix = 32'h0000_0000;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg  <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      dvd_reg    <= '0;
      dvs_reg    <= '0;
      quo_reg    <= '0;
      rem_reg    <= '0;
      result_reg <= '0;
      qo_reg     <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      div0_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      if (accept) begin
        op_reg <= bus.op;
        a_reg  <= bus.dividend;
        b_reg  <= bus.divisor;
`ifdef DIV_FASTPATH_EN
        if (fast_hit) begin
          qo_reg     <= fast_q;
          result_reg <= op_is_rem(bus.op) ? fast_r : fast_q;
        end
`endif
      end
      // A flush must not let a half-finished operation touch the results.
      if (!bus.kill) begin
        case (state_reg)
          PREP: begin
            dvd_reg   <= (sgn && a_reg[31]) ? -a_reg : a_reg;
            dvs_reg   <= (sgn && b_reg[31]) ? -b_reg : b_reg;
            rem_reg   <= '0;
            quo_reg   <= '0;
            count_reg <= 5'd31;
            neg_q_reg <= sgn && (a_reg[31] ^ b_reg[31]);
            neg_r_reg <= sgn && a_reg[31];
            div0_reg  <= (b_reg == 32'h0000_0000);
            ovf_reg   <= sgn && (a_reg == 32'h8000_0000) && (b_reg == 32'hFFFF_FFFF);
          end
          ITER: begin
            rem_reg <= rem_step;
            dvd_reg <= {dvd_reg[30:0], 1'b0};
            quo_reg <= {quo_reg[30:0], q_step};
            if (count_reg != 5'd0) count_reg <= count_reg - 5'd1;
          end
          FIX: begin
            qo_reg     <= q_fix;
            result_reg <= op_is_rem(op_reg) ? r_fix : q_fix;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy     = (state_reg == PREP) || (state_reg == ITER) || (state_reg == FIX);
  assign bus.div_last = (state_reg == DONE);
  assign bus.result   = result_reg;
  assign bus.Qo       = qo_reg;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: arithmetic, corner cases, latency, kill and reset behaviour.
module tb_div_sequencer;
  import instruction_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  div_sequencer_if bus_if ();

  div_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  localparam int LAT_NORMAL = 35;
`ifdef DIV_FASTPATH_EN
  localparam int   LAT_SPECIAL  = 1;
  localparam logic BUSY_SPECIAL = 1'b0;
`else
  localparam int   LAT_SPECIAL  = 35;
  localparam logic BUSY_SPECIAL = 1'b1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic exp_busy);
    bus_if.op       = op;
    bus_if.dividend = a;
    bus_if.divisor  = b;
    bus_if.start    = 1'b1;
    step();
    bus_if.start = 1'b0;
    cyc = 1;
    chk({tag, ".busy_c1"}, {31'b0, bus_if.busy}, {31'b0, exp_busy});
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res,
                           input logic [31:0] exp_qo);
    while (bus_if.div_last !== 1'b1 && cyc < 60) step();
    chk({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, ".result"}, bus_if.result, exp_res);
    chk({tag, ".Qo"}, bus_if.Qo, exp_qo);
    chk({tag, ".busy_done"}, {31'b0, bus_if.busy}, 32'd0);
    $display("op %s: latency=%0d result=0x%08h Qo=0x%08h", tag, cyc, bus_if.result, bus_if.Qo);
  endtask

  initial begin
    int last_cnt;
    bus_if.start    = 1'b0;
    bus_if.kill     = 1'b0;
    bus_if.op       = FUNCT3_DIVU;
    bus_if.dividend = '0;
    bus_if.divisor  = '0;

    // Reset held with the clock running.
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", {31'b0, bus_if.busy}, 32'd0);
    chk("rst.div_last", {31'b0, bus_if.div_last}, 32'd0);
    chk("rst.result", bus_if.result, 32'd0);
    chk("rst.Qo", bus_if.Qo, 32'd0);
    reset = 1'b1;
    step();

    issue("divu_100_7", FUNCT3_DIVU, 32'd100, 32'd7, 1'b1);
    wait_done("divu_100_7", LAT_NORMAL, 32'd14, 32'd14);
    issue("remu_100_7", FUNCT3_REMU, 32'd100, 32'd7, 1'b1);
    wait_done("remu_100_7", LAT_NORMAL, 32'd2, 32'd14);
    issue("div_m7_2", FUNCT3_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("div_m7_2", LAT_NORMAL, 32'hFFFF_FFFD, 32'hFFFF_FFFD);
    issue("rem_m7_2", FUNCT3_REM, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("rem_m7_2", LAT_NORMAL, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // Divide by zero, unsigned and signed, positive and negative dividend.
    issue("divu_5_0", FUNCT3_DIVU, 32'd5, 32'd0, BUSY_SPECIAL);
    wait_done("divu_5_0", LAT_SPECIAL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue("rem_5_0", FUNCT3_REM, 32'd5, 32'd0, BUSY_SPECIAL);
    wait_done("rem_5_0", LAT_SPECIAL, 32'd5, 32'hFFFF_FFFF);
    issue("div_m5_0", FUNCT3_DIV, 32'hFFFF_FFFB, 32'd0, BUSY_SPECIAL);
    wait_done("div_m5_0", LAT_SPECIAL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue("rem_m5_0", FUNCT3_REM, 32'hFFFF_FFFB, 32'd0, BUSY_SPECIAL);
    wait_done("rem_m5_0", LAT_SPECIAL, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // Signed overflow.
    issue("div_ovf", FUNCT3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, BUSY_SPECIAL);
    wait_done("div_ovf", LAT_SPECIAL, 32'h8000_0000, 32'h8000_0000);
    issue("rem_ovf", FUNCT3_REM, 32'h8000_0000, 32'hFFFF_FFFF, BUSY_SPECIAL);
    wait_done("rem_ovf", LAT_SPECIAL, 32'd0, 32'h8000_0000);

    // Let DONE fall back to IDLE, then kill in the 10th ITER cycle (cycle 11 after start).
    repeat (3) step();
    chk("idle.busy", {31'b0, bus_if.busy}, 32'd0);
    chk("idle.div_last", {31'b0, bus_if.div_last}, 32'd0);
    issue("kill_op", FUNCT3_DIVU, 32'd1000, 32'd3, 1'b1);
    while (cyc < 11) step();
    chk("kill.busy_before", {31'b0, bus_if.busy}, 32'd1);
    bus_if.kill = 1'b1;
    step();
    bus_if.kill = 1'b0;
    chk("kill.busy_after", {31'b0, bus_if.busy}, 32'd0);
    chk("kill.div_last_after", {31'b0, bus_if.div_last}, 32'd0);
    last_cnt = 0;
    repeat (40) begin
      step();
      if (bus_if.div_last === 1'b1) last_cnt++;
    end
    chk("kill.no_div_last", 32'(last_cnt), 32'd0);
    chk("kill.Qo_kept", bus_if.Qo, 32'h8000_0000);
    chk("kill.result_kept", bus_if.result, 32'd0);
    $display("kill: busy=%0d div_last_pulses=%0d", bus_if.busy, last_cnt);

    // kill wins over a simultaneous start.
    bus_if.op       = FUNCT3_DIVU;
    bus_if.dividend = 32'd50;
    bus_if.divisor  = 32'd5;
    bus_if.start    = 1'b1;
    bus_if.kill     = 1'b1;
    step();
    bus_if.start = 1'b0;
    bus_if.kill  = 1'b0;
    chk("kill_vs_start.busy", {31'b0, bus_if.busy}, 32'd0);
    $display("kill+start: busy=%0d", bus_if.busy);

    issue("divu_9_3", FUNCT3_DIVU, 32'd9, 32'd3, 1'b1);
    wait_done("divu_9_3", LAT_NORMAL, 32'd3, 32'd3);

    // Back-to-back from DONE; a start while busy must be ignored.
    issue("divu_50_5", FUNCT3_DIVU, 32'd50, 32'd5, 1'b1);
    repeat (3) step();
    bus_if.dividend = 32'd7;
    bus_if.divisor  = 32'd7;
    bus_if.start    = 1'b1;
    step();
    bus_if.start = 1'b0;
    wait_done("divu_50_5", LAT_NORMAL, 32'd10, 32'd10);

    // Asynchronous reset in the middle of ITER.
    issue("rst_mid", FUNCT3_DIVU, 32'd100, 32'd7, 1'b1);
    while (cyc < 15) step();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid.busy", {31'b0, bus_if.busy}, 32'd0);
    chk("rst_mid.div_last", {31'b0, bus_if.div_last}, 32'd0);
    chk("rst_mid.result", bus_if.result, 32'd0);
    chk("rst_mid.Qo", bus_if.Qo, 32'd0);
    $display("reset mid-ITER: busy=%0d result=0x%08h Qo=0x%08h",
             bus_if.busy, bus_if.result, bus_if.Qo);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    issue("after_rst", FUNCT3_DIVU, 32'd9, 32'd3, 1'b1);
    wait_done("after_rst", LAT_NORMAL, 32'd3, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
